vram_arbiter: RTL

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/ppu_pkg.sv | 38 +++
 rtl/rd_return_pipe.sv | 63 ++++++
 rtl/vram_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types and constants for the PPU/CPU VRAM arbitration slice.
// Latency: n/a (types only).  Backpressure: n/a.
// Contents: ppu_mode_t, arb_state_t, owner_t, rd_tag_t, VRAM_AW, LOCK_RDATA.
package ppu_pkg;

  localparam int VRAM_AW = 13;
  localparam logic [7:0] LOCK_RDATA = 8'hFF;

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_XFER   = 2'd3
  } ppu_mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PPU  = 2'd1,
    S_CPU  = 2'd2,
    S_LOCK = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_PPU  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_LOCK = 2'd3
  } owner_t;

  // One return-pipe slot: a BRAM read (owned by PPU or CPU) and, independently,
  // a locked-out CPU read. Both can be issued in the same cycle.
  typedef struct packed {
    logic   bram_vld;
    owner_t bram_own;
    logic   lock_vld;
  } rd_tag_t;

endpackage

// File: rtl/rd_return_pipe.sv
// rd_return_pipe: delays read tags by BRAM_LAT cycles and steers the returning
// data (bram_dout, or LOCK_RDATA for locked-out CPU reads) to the owner.
// Latency: rvalid exactly BRAM_LAT cycles after the grant; no backpressure.
// Ports: clk, rst (sync, active-high), tag_in, bram_dout -> ppu/cpu rvalid+rdata.
module rd_return_pipe
  import ppu_pkg::*;
#(
  parameter int BRAM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  rd_tag_t    tag_in,
  input  logic [7:0] bram_dout,
  output logic       ppu_rvalid,
  output logic [7:0] ppu_rdata,
  output logic       cpu_rvalid,
  output logic [7:0] cpu_rdata
);

  rd_tag_t    pipe_q [BRAM_LAT];
  rd_tag_t    head;
  logic       ppu_hit;
  logic       cpu_bram_hit;
  logic       cpu_lock_hit;
  logic [7:0] cpu_src;
  logic [7:0] ppu_hold_q;
  logic [7:0] cpu_hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BRAM_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < BRAM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    head         = pipe_q[BRAM_LAT-1];
    ppu_hit      = head.bram_vld && (head.bram_own == OWN_PPU);
    cpu_bram_hit = head.bram_vld && (head.bram_own == OWN_CPU);
    cpu_lock_hit = head.lock_vld;
    cpu_src      = cpu_lock_hit ? LOCK_RDATA : bram_dout;
    // rst gating keeps in-flight reads from surfacing during the reset cycle
    // itself, before the pipe has been cleared by the first reset edge.
    ppu_rvalid   = !rst && ppu_hit;
    cpu_rvalid   = !rst && (cpu_bram_hit || cpu_lock_hit);
    ppu_rdata    = rst ? 8'h00 : (ppu_rvalid ? bram_dout : ppu_hold_q);
    cpu_rdata    = rst ? 8'h00 : (cpu_rvalid ? cpu_src : cpu_hold_q);
  end

  // rdata holds the last returned byte while rvalid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      ppu_hold_q <= 8'h00;
      cpu_hold_q <= 8'h00;
    end else begin
      if (ppu_rvalid) ppu_hold_q <= bram_dout;
      if (cpu_rvalid) cpu_hold_q <= cpu_src;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM BRAM arbiter between PPU reads and CPU reads/writes.
// Latency: ack combinational in the grant cycle; rdata/rvalid BRAM_LAT cycles later.
// Backpressure: requester holds req until ack; PPU has priority, CPU gets in after
// STARVE_MAX consecutive PPU wins (not during the mode-3 window).
// Ports: clk, rst (sync, active-high); ppu_* read port; cpu_* read/write port;
// ppu_mode/lcd_on PPU status; bram_* to the VRAM block RAM.
// Build option: define VRAM_LOCKOUT_EN to ack CPU accesses inside the mode-3
// window without touching BRAM (reads return LOCK_RDATA, writes are dropped).
module vram_arbiter
  import ppu_pkg::*;
#(
  parameter int BRAM_LAT   = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ppu_req,
  input  logic [VRAM_AW-1:0] ppu_a,
  output logic               ppu_ack,
  output logic [7:0]         ppu_rdata,
  output logic               ppu_rvalid,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [VRAM_AW-1:0] cpu_a,
  input  logic [7:0]         cpu_wdata,
  output logic               cpu_ack,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_rvalid,
  input  logic [1:0]         ppu_mode,
  input  logic               lcd_on,
  output logic [VRAM_AW-1:0] bram_a,
  output logic [7:0]         bram_din,
  output logic               bram_we,
  input  logic [7:0]         bram_dout
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  arb_state_t    state_q;
  arb_state_t    state_d;
  logic [SW-1:0] starve_cnt_q;
  logic          window;
  logic          starve_hit;
  logic          lock_ack;
  logic          cpu_gnt;
  logic          ppu_gnt;
  rd_tag_t       tag;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    window     = lcd_on && (ppu_mode_t'(ppu_mode) == MODE_XFER);
    // The starvation override never applies inside the transfer window.
    starve_hit = (starve_cnt_q == STARVE_TOP) && !window;
`ifdef VRAM_LOCKOUT_EN
    lock_ack   = !rst && cpu_req && window;
`else
    lock_ack   = 1'b0;
`endif
    cpu_gnt    = !rst && cpu_req && !lock_ack && (!ppu_req || starve_hit);
    ppu_gnt    = !rst && ppu_req && !cpu_gnt;

    ppu_ack    = ppu_gnt;
    cpu_ack    = cpu_gnt || lock_ack;

    bram_a     = '0;
    bram_din   = 8'h00;
    bram_we    = 1'b0;
    if (ppu_gnt) begin
      bram_a   = ppu_a;
    end else if (cpu_gnt) begin
      bram_a   = cpu_a;
      bram_din = cpu_wdata;
      bram_we  = cpu_we;
    end

    tag.bram_vld = ppu_gnt || (cpu_gnt && !cpu_we);
    tag.bram_own = ppu_gnt ? OWN_PPU : (cpu_gnt ? OWN_CPU : OWN_NONE);
    tag.lock_vld = lock_ack && !cpu_we;

    // A PPU grant coinciding with a lockout ack still records the PPU.
    state_d = S_IDLE;
    if (ppu_gnt)       state_d = S_PPU;
    else if (cpu_gnt)  state_d = S_CPU;
    else if (lock_ack) state_d = S_LOCK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else if (!cpu_req || cpu_ack) begin
      starve_cnt_q <= '0;
    end else if (ppu_gnt && (starve_cnt_q != STARVE_TOP)) begin
      starve_cnt_q <= starve_cnt_q + SW'(1);
    end
  end

  // A waiting count can only exist right after a PPU grant.
  a_starve_after_ppu : assert property (@(posedge clk) disable iff (rst)
    (starve_cnt_q != '0) |-> (state_q == S_PPU));

  rd_return_pipe #(.BRAM_LAT(BRAM_LAT)) u_rd_return_pipe (
    .clk        (clk),
    .rst        (rst),
    .tag_in     (tag),
    .bram_dout  (bram_dout),
    .ppu_rvalid (ppu_rvalid),
    .ppu_rdata  (ppu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata)
  );

endmodule
